// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// access-size decoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    // Anything outside the legal encodings for the access type is a word access.
    function automatic size_e decode_size(input logic [2:0] funct3, input logic store);
        size_e size;
        size = SzWord;
        if (store) begin
            if (funct3 == F3_B) size = SzByte;
            else if (funct3 == F3_H) size = SzHalf;
        end else begin
            if (funct3 == F3_B || funct3 == F3_BU) size = SzByte;
            else if (funct3 == F3_H || funct3 == F3_HU) size = SzHalf;
        end
        return size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, byte enables, misalignment detection and load extension
// for a single 32-bit data-memory access.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_lane,
    output logic [3:0]  be,
    output logic        misaligned,
    output logic [31:0] rdata_ext
);

    size_e       size;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_ext;

    assign size      = decode_size(funct3, store);
    assign byte_lane = 8'(rdata >> {addr_lo, 3'b000});
    assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    // lb/lh have funct3[2] clear, lbu/lhu have it set.
    assign sign_ext  = ~funct3[2];

    always_comb begin
        wdata_lane = wdata;
        be         = 4'b1111;
        misaligned = 1'b0;
        rdata_ext  = rdata;
        unique case (size)
            SzByte: begin
                wdata_lane = {4{wdata[7:0]}};
                be         = 4'b0001 << addr_lo;
                rdata_ext  = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            SzHalf: begin
                wdata_lane = {2{wdata[15:0]}};
                be         = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                rdata_ext  = {{16{sign_ext & half_lane[15]}}, half_lane};
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: one single-beat bus transaction per request, stalling
// the pipeline until the access completes, errors out, or is rejected as misaligned.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int unsigned   CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      addr_lo_q;
    logic [2:0]      funct3_q;

    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
    logic [3:0]  mem_be_q;
    logic        rdata_valid_q, misaligned_q, bus_err_q;

    logic        idle, busy, req, start;
    logic        ack_done, timed_out;
    logic [1:0]  sel_addr_lo;
    logic [2:0]  sel_funct3;
    logic        sel_store;
    logic [31:0] al_wdata, al_rdata;
    logic [3:0]  al_be;
    logic        al_misaligned;

    assign idle = (state_q == StIdle);
    assign busy = (state_q == StBusy);
    assign req  = load_i | store_i;

    // One aligner serves both paths: live request fields while idle for steering,
    // latched fields while busy for extracting the returned data.
    assign sel_addr_lo = idle ? addr_i[1:0] : addr_lo_q;
    assign sel_funct3  = idle ? funct3_i : funct3_q;
    assign sel_store   = idle ? store_i : mem_we_q;

    lsu_align u_align (
        .addr_lo    (sel_addr_lo),
        .funct3     (sel_funct3),
        .store      (sel_store),
        .wdata      (wdata_i),
        .rdata      (mem_rdata_i),
        .wdata_lane (al_wdata),
        .be         (al_be),
        .misaligned (al_misaligned),
        .rdata_ext  (al_rdata)
    );

    assign start     = idle & req & ~al_misaligned;
    assign ack_done  = busy & mem_ack_i;
    assign timed_out = busy & ~mem_ack_i & (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = al_misaligned ? StDone : StBusy;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                if (mem_ack_i || cnt_q == CntLast) state_d = StDone;
                else cnt_d = cnt_q + 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            addr_lo_q     <= '0;
            funct3_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            mem_req_q     <= (state_d == StBusy);
            rdata_valid_q <= ack_done & ~mem_we_q;
            misaligned_q  <= idle & req & al_misaligned;
            bus_err_q     <= timed_out;
            if (start) begin
                mem_we_q    <= store_i;
                mem_addr_q  <= {addr_i[31:2], 2'b00};
                mem_wdata_q <= al_wdata;
                mem_be_q    <= al_be;
                addr_lo_q   <= addr_i[1:0];
                funct3_q    <= funct3_i;
            end
            if (ack_done && !mem_we_q) rdata_q <= al_rdata;
            else if (timed_out) rdata_q <= '0;
        end
    end

    assign stall_o       = (idle & req) | busy;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_be_o      = mem_be_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign misaligned_o  = misaligned_q;
    assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table of accesses, pulse/bus scoreboards,
// plus reset and reset-during-BUSY sequences.
module tb_lsu;
    import lsu_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i, wdata_i, mem_rdata_i;
    logic        load_i, store_i, mem_ack_i;
    logic [2:0]  funct3_i;
    logic        stall_o, rdata_valid_o, misaligned_o, bus_err_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(TO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .load_i        (load_i),
        .store_i       (store_i),
        .funct3_i      (funct3_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .misaligned_o  (misaligned_o),
        .bus_err_o     (bus_err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_be_o      (mem_be_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_ack_i     (mem_ack_i)
    );

    typedef struct {
        logic ld; logic st; logic [2:0] f3;
        logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; int ack_dly;
        logic [31:0] e_maddr; logic [31:0] e_wdata; logic [3:0] e_be; logic e_we;
        logic [31:0] e_rdata; logic e_valid; logic e_mis; logic e_err;
        int e_stalls; int e_reqs;
    } vec_t;

    typedef struct { logic [31:0] rdata; logic valid; logic mis; logic err; } pulse_t;
    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we; } bus_t;

    pulse_t      pq[$];
    bus_t        bq[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] last_rdata = 32'h0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // ack_dly = 0 means the bus never acknowledges.
    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int ack,
                                input logic [31:0] e_wdata, input logic [3:0] e_be,
                                input logic [31:0] e_rdata, input logic e_mis);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.ack_dly = ack;
        v.e_maddr = {addr[31:2], 2'b00}; v.e_wdata = e_wdata; v.e_be = e_be; v.e_we = st;
        v.e_rdata = e_rdata; v.e_mis = e_mis;
        v.e_err = !e_mis && ack == 0;
        v.e_valid = ld && !st && !e_mis && ack > 0;
        v.e_stalls = e_mis ? 1 : (ack > 0 ? ack + 1 : int'(TO) + 1);
        v.e_reqs = e_mis ? 0 : (ack > 0 ? ack : int'(TO));
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (rdata_valid_o || misaligned_o || bus_err_o) begin
                if (pq.size() == 0) begin
                    chk("unexpected_pulse", {29'd0, rdata_valid_o, misaligned_o, bus_err_o}, 32'd0);
                end else begin
                    pulse_t p;
                    p = pq.pop_front();
                    chk("rdata_valid_o", rdata_valid_o, p.valid);
                    chk("misaligned_o", misaligned_o, p.mis);
                    chk("bus_err_o", bus_err_o, p.err);
                    if (p.valid || p.err) chk("rdata_o", rdata_o, p.rdata);
                end
            end
            if (mem_req_o && mem_ack_i) begin
                if (bq.size() == 0) begin
                    chk("unexpected_bus_ack", 32'd1, 32'd0);
                end else begin
                    bus_t b;
                    b = bq.pop_front();
                    chk("mem_addr_o", mem_addr_o, b.addr);
                    chk("mem_wdata_o", mem_wdata_o, b.wdata);
                    chk("mem_be_o", mem_be_o, b.be);
                    chk("mem_we_o", mem_we_o, b.we);
                end
            end
        end
    end

    task automatic run(input vec_t v);
        int stalls = 0;
        int reqs = 0;
        int bad = 0;
        bit done = 0;
        if (v.e_valid || v.e_mis || v.e_err)
            pq.push_back('{v.e_rdata, v.e_valid, v.e_mis, v.e_err});
        if (!v.e_mis && v.ack_dly > 0)
            bq.push_back('{v.e_maddr, v.e_wdata, v.e_be, v.e_we});
        for (int c = 0; c <= int'(TO) + 3; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                load_i = v.ld; store_i = v.st; funct3_i = v.f3;
                addr_i = v.addr; wdata_i = v.wdata;
            end
            mem_ack_i   = (c > 0 && c == v.ack_dly);
            mem_rdata_i = mem_ack_i ? v.rdata : $urandom;
            @(negedge clk);
            if (stall_o) stalls++;
            if (mem_req_o) begin
                reqs++;
                if (mem_addr_o !== v.e_maddr || mem_be_o !== v.e_be ||
                    mem_we_o !== v.e_we || mem_wdata_o !== v.e_wdata) bad++;
            end
            if (c > 0 && !stall_o) begin
                done = 1;
                break;
            end
        end
        @(posedge clk); #1;
        load_i = 1'b0; store_i = 1'b0; mem_ack_i = 1'b0;
        chk("done_reached", {31'd0, done}, 32'd1);
        chk("stall_cycles", stalls, v.e_stalls);
        chk("req_cycles", reqs, v.e_reqs);
        chk("bus_fields_stable", bad, 0);
        chk("pulse_queue_drained", pq.size(), 0);
        chk("bus_queue_drained", bq.size(), 0);
        if (v.e_valid) last_rdata = v.e_rdata;
        if (v.e_err) last_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1; load_i = 1'b0; store_i = 1'b0; funct3_i = 3'b0;
        addr_i = '0; wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;

        //      ld st f3      addr          wdata         rdata        ack e_wdata       be       e_rdata       mis
        vecs.push_back(mk(0, 1, F3_W,  32'h1000_0004, 32'hDEAD_BEEF, 32'h0,        2, 32'hDEAD_BEEF, 4'b1111, 32'h0,        0));
        vecs.push_back(mk(1, 0, F3_B,  32'h1000_0003, 32'h0,         32'h80FF_1234, 1, 32'h0,        4'b1000, 32'hFFFF_FF80, 0));
        vecs.push_back(mk(1, 0, F3_BU, 32'h1000_0003, 32'h0,         32'h80FF_1234, 2, 32'h0,        4'b1000, 32'h0000_0080, 0));
        vecs.push_back(mk(0, 1, F3_H,  32'h2000_0002, 32'h0000_ABCD, 32'h0,        1, 32'hABCD_ABCD, 4'b1100, 32'h0,        0));
        vecs.push_back(mk(1, 0, F3_W,  32'h2000_0001, 32'h0,         32'h0,        1, 32'h0,        4'b0000, 32'h0,        1));
        vecs.push_back(mk(1, 0, F3_H,  32'h3000_0002, 32'h0,         32'h8001_7FFF, 3, 32'h0,        4'b1100, 32'hFFFF_8001, 0));
        vecs.push_back(mk(1, 0, F3_HU, 32'h3000_0000, 32'h0,         32'h8001_7FFF, 1, 32'h0,        4'b0011, 32'h0000_7FFF, 0));
        vecs.push_back(mk(1, 0, F3_B,  32'h3000_0001, 32'h0,         32'h0000_3400, 1, 32'h0,        4'b0010, 32'h0000_0034, 0));
        vecs.push_back(mk(0, 1, F3_B,  32'h4000_0001, 32'h1234_56A5, 32'h0,        1, 32'hA5A5_A5A5, 4'b0010, 32'h0,        0));
        vecs.push_back(mk(1, 1, F3_W,  32'h5000_0000, 32'h1122_3344, 32'h5566_7788, 1, 32'h1122_3344, 4'b1111, 32'h0,        0));
        vecs.push_back(mk(1, 0, F3_W,  32'h6000_0000, 32'h0,         32'h0,        0, 32'h0,        4'b1111, 32'h0,        0));
        vecs.push_back(mk(1, 0, F3_W,  32'h6000_0004, 32'h0,         32'h0BAD_F00D, 1, 32'h0,        4'b1111, 32'h0BAD_F00D, 0));
        vecs.push_back(mk(1, 0, F3_BU, 32'h7000_0002, 32'h0,         32'h00AB_0000, 4, 32'h0,        4'b0100, 32'h0000_00AB, 0));
        vecs.push_back(mk(0, 1, F3_H,  32'h7000_0003, 32'h0000_FFFF, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        1));
        vecs.push_back(mk(1, 0, 3'b011, 32'h8000_0004, 32'h0,        32'h1357_9BDF, 1, 32'h0,        4'b1111, 32'h1357_9BDF, 0));
        vecs.push_back(mk(0, 1, F3_B,  32'hA000_0003, 32'h0000_00C3, 32'h0,        2, 32'hC3C3_C3C3, 4'b1000, 32'h0,        0));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req_o", mem_req_o, 0);
        chk("rst_mem_we_o", mem_we_o, 0);
        chk("rst_mem_addr_o", mem_addr_o, 0);
        chk("rst_mem_wdata_o", mem_wdata_o, 0);
        chk("rst_mem_be_o", mem_be_o, 0);
        chk("rst_rdata_o", rdata_o, 0);
        chk("rst_rdata_valid_o", rdata_valid_o, 0);
        chk("rst_misaligned_o", misaligned_o, 0);
        chk("rst_bus_err_o", bus_err_o, 0);
        chk("rst_stall_o", stall_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) run(vecs[i]);
        chk("rdata_held", rdata_o, last_rdata);

        // Reset in the middle of BUSY; a late ack must be ignored.
        @(posedge clk); #1;
        load_i = 1'b1; funct3_i = F3_W; addr_i = 32'hB000_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_req_before_rst", mem_req_o, 1);
        load_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_req_drop", mem_req_o, 0);
        chk("async_addr_clear", mem_addr_o, 0);
        chk("async_rdata_clear", rdata_o, 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFEED_FACE;
        @(negedge clk);
        chk("late_ack_no_req", mem_req_o, 0);
        chk("late_ack_no_stall", stall_o, 0);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        chk("late_ack_no_valid", rdata_valid_o, 0);
        chk("late_ack_rdata", rdata_o, 0);
        last_rdata = 32'h0;

        run(mk(1, 0, F3_H, 32'hC000_0000, 32'h0, 32'h1234_8765, 1, 32'h0, 4'b0011,
               32'hFFFF_8765, 0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
